// File: rtl/bpm_link_pkg.sv
// Shared definitions for the BPM fast-acquisition link. The header format lives
// here so the transmitter and the cell controller's reader always agree on it.
package bpm_link_pkg;

    localparam int          FOFB_INDEX_WIDTH = 9;
    localparam logic [15:0] HEADER_MAGIC     = 16'hA5BC;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_X,
        ST_Y,
        ST_S
    } chan_state_e;

    function automatic logic [31:0] pack_header(input logic [15:0] magic,
                                                input logic [15:0] index);
        return {magic, index};
    endfunction

endpackage

// File: rtl/bpm_link_tx_channel.sv
// One BPM link transmit channel: captures a sample on the FA strobe, then sends
// header/X/Y/S on an AXI stream and keeps saturating packet and overrun counts.
module bpm_link_tx_channel
    import bpm_link_pkg::*;
#(
    parameter int          IDX_W = 9,
    parameter logic [15:0] MAGIC = 16'hA5BC,
    parameter int          CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             strobe_i,
    input  logic             inhibit_i,
    input  logic [IDX_W-1:0] index_i,
    input  logic [31:0]      x_i,
    input  logic [31:0]      y_i,
    input  logic [31:0]      s_i,
    input  logic             tready_i,
    output logic [31:0]      tdata_o,
    output logic             tvalid_o,
    output logic             tlast_o,
    output logic [CNT_W-1:0] pkt_count_o,
    output logic [CNT_W-1:0] ovr_count_o
);

    chan_state_e      state_q, state_d;
    logic [31:0]      tdata_q, tdata_d;
    logic             tvalid_q, tvalid_d;
    logic             tlast_q, tlast_d;
    logic [CNT_W-1:0] pkt_q, pkt_d;
    logic [CNT_W-1:0] ovr_q, ovr_d;
    logic [31:0]      x_q, y_q, s_q;
    logic [15:0]      idx_ext;
    logic             capture;
    logic             pkt_inc;
    logic             ovr_inc;

    always_comb begin
        idx_ext  = 16'(index_i);
        state_d  = state_q;
        tdata_d  = tdata_q;
        tvalid_d = tvalid_q;
        tlast_d  = tlast_q;
        capture  = 1'b0;
        pkt_inc  = 1'b0;
        // Any strobe outside IDLE is busy, including the cycle S is accepted.
        ovr_inc  = strobe_i && (state_q != ST_IDLE);

        unique case (state_q)
            ST_IDLE: begin
                if (strobe_i && !inhibit_i) begin
                    state_d  = ST_HDR;
                    tdata_d  = pack_header(MAGIC, idx_ext);
                    tvalid_d = 1'b1;
                    capture  = 1'b1;
                end
            end
            ST_HDR: begin
                if (tready_i) begin
                    state_d = ST_X;
                    tdata_d = x_q;
                end
            end
            ST_X: begin
                if (tready_i) begin
                    state_d = ST_Y;
                    tdata_d = y_q;
                end
            end
            ST_Y: begin
                if (tready_i) begin
                    state_d = ST_S;
                    tdata_d = s_q;
                    tlast_d = 1'b1;
                end
            end
            ST_S: begin
                if (tready_i) begin
                    state_d  = ST_IDLE;
                    tvalid_d = 1'b0;
                    tlast_d  = 1'b0;
                    pkt_inc  = 1'b1;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                tvalid_d = 1'b0;
                tlast_d  = 1'b0;
            end
        endcase

        pkt_d = (pkt_inc && (pkt_q != '1)) ? pkt_q + CNT_W'(1) : pkt_q;
        ovr_d = (ovr_inc && (ovr_q != '1)) ? ovr_q + CNT_W'(1) : ovr_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            pkt_q    <= '0;
            ovr_q    <= '0;
        end else begin
            state_q  <= state_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
            pkt_q    <= pkt_d;
            ovr_q    <= ovr_d;
        end
    end

    // Sample payload needs no reset; it is only read after a fresh capture.
    always_ff @(posedge clk_i) begin
        if (capture) begin
            x_q <= x_i;
            y_q <= y_i;
            s_q <= s_i;
        end
    end

    assign tdata_o     = tdata_q;
    assign tvalid_o    = tvalid_q;
    assign tlast_o     = tlast_q;
    assign pkt_count_o = pkt_q;
    assign ovr_count_o = ovr_q;

endmodule

// File: rtl/bpm_link_tx.sv
// BPM fast-acquisition link transmitter: two independent channels (CW and CCW)
// fed from the same FA strobe and sample, each with its own inhibit and stream.
module bpm_link_tx #(
    parameter int          FOFB_INDEX_WIDTH = bpm_link_pkg::FOFB_INDEX_WIDTH,
    parameter logic [15:0] HEADER_MAGIC     = bpm_link_pkg::HEADER_MAGIC,
    parameter int          COUNTER_WIDTH    = 16
) (
    input  logic                        auroraUserClk,
    input  logic                        auroraReset,
    input  logic                        faStrobe,
    input  logic [FOFB_INDEX_WIDTH-1:0] fofbIndex,
    input  logic [31:0]                 faX,
    input  logic [31:0]                 faY,
    input  logic [31:0]                 faS,
    input  logic                        cwInhibit,
    input  logic                        ccwInhibit,
    output logic [31:0]                 BPM_CW_AXI_STREAM_TX_tdata,
    output logic                        BPM_CW_AXI_STREAM_TX_tvalid,
    output logic                        BPM_CW_AXI_STREAM_TX_tlast,
    input  logic                        BPM_CW_AXI_STREAM_TX_tready,
    output logic [31:0]                 BPM_CCW_AXI_STREAM_TX_tdata,
    output logic                        BPM_CCW_AXI_STREAM_TX_tvalid,
    output logic                        BPM_CCW_AXI_STREAM_TX_tlast,
    input  logic                        BPM_CCW_AXI_STREAM_TX_tready,
    output logic [COUNTER_WIDTH-1:0]    cwPacketCount,
    output logic [COUNTER_WIDTH-1:0]    ccwPacketCount,
    output logic [COUNTER_WIDTH-1:0]    cwOverrunCount,
    output logic [COUNTER_WIDTH-1:0]    ccwOverrunCount
);

    bpm_link_tx_channel #(
        .IDX_W (FOFB_INDEX_WIDTH),
        .MAGIC (HEADER_MAGIC),
        .CNT_W (COUNTER_WIDTH)
    ) u_cw (
        .clk_i       (auroraUserClk),
        .rst_i       (auroraReset),
        .strobe_i    (faStrobe),
        .inhibit_i   (cwInhibit),
        .index_i     (fofbIndex),
        .x_i         (faX),
        .y_i         (faY),
        .s_i         (faS),
        .tready_i    (BPM_CW_AXI_STREAM_TX_tready),
        .tdata_o     (BPM_CW_AXI_STREAM_TX_tdata),
        .tvalid_o    (BPM_CW_AXI_STREAM_TX_tvalid),
        .tlast_o     (BPM_CW_AXI_STREAM_TX_tlast),
        .pkt_count_o (cwPacketCount),
        .ovr_count_o (cwOverrunCount)
    );

    bpm_link_tx_channel #(
        .IDX_W (FOFB_INDEX_WIDTH),
        .MAGIC (HEADER_MAGIC),
        .CNT_W (COUNTER_WIDTH)
    ) u_ccw (
        .clk_i       (auroraUserClk),
        .rst_i       (auroraReset),
        .strobe_i    (faStrobe),
        .inhibit_i   (ccwInhibit),
        .index_i     (fofbIndex),
        .x_i         (faX),
        .y_i         (faY),
        .s_i         (faS),
        .tready_i    (BPM_CCW_AXI_STREAM_TX_tready),
        .tdata_o     (BPM_CCW_AXI_STREAM_TX_tdata),
        .tvalid_o    (BPM_CCW_AXI_STREAM_TX_tvalid),
        .tlast_o     (BPM_CCW_AXI_STREAM_TX_tlast),
        .pkt_count_o (ccwPacketCount),
        .ovr_count_o (ccwOverrunCount)
    );

endmodule

// File: tb/tb_bpm_link_tx.sv
// Bench for bpm_link_tx: a packet-queue model of both links checked every cycle,
// directed scenarios with literal expectations, and randomized traffic.
module tb_bpm_link_tx;

    localparam int SAT_W = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic        strobe;
    logic [8:0]  idx;
    logic [31:0] fx, fy, fs;
    logic        cw_inh, ccw_inh;
    logic        cw_rdy, ccw_rdy;

    logic [31:0] cw_d, ccw_d;
    logic        cw_v, ccw_v, cw_l, ccw_l;
    logic [15:0] cw_pkt, ccw_pkt, cw_ovr, ccw_ovr;

    logic [31:0]      s_cw_d, s_ccw_d;
    logic             s_cw_v, s_ccw_v, s_cw_l, s_ccw_l;
    logic [SAT_W-1:0] s_cw_pkt, s_ccw_pkt, s_cw_ovr, s_ccw_ovr;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model: per link, the words still to be sent ({tlast, tdata}) plus raw event counts.
    logic [32:0] mq [2][$];
    int pkt_raw [2];
    int ovr_raw [2];

    always #5 clk = ~clk;

    bpm_link_tx dut (
        .auroraUserClk                (clk),
        .auroraReset                  (rst),
        .faStrobe                     (strobe),
        .fofbIndex                    (idx),
        .faX                          (fx),
        .faY                          (fy),
        .faS                          (fs),
        .cwInhibit                    (cw_inh),
        .ccwInhibit                   (ccw_inh),
        .BPM_CW_AXI_STREAM_TX_tdata   (cw_d),
        .BPM_CW_AXI_STREAM_TX_tvalid  (cw_v),
        .BPM_CW_AXI_STREAM_TX_tlast   (cw_l),
        .BPM_CW_AXI_STREAM_TX_tready  (cw_rdy),
        .BPM_CCW_AXI_STREAM_TX_tdata  (ccw_d),
        .BPM_CCW_AXI_STREAM_TX_tvalid (ccw_v),
        .BPM_CCW_AXI_STREAM_TX_tlast  (ccw_l),
        .BPM_CCW_AXI_STREAM_TX_tready (ccw_rdy),
        .cwPacketCount                (cw_pkt),
        .ccwPacketCount               (ccw_pkt),
        .cwOverrunCount               (cw_ovr),
        .ccwOverrunCount              (ccw_ovr)
    );

    // Narrow-counter instance so saturation is reachable in a short run.
    bpm_link_tx #(.COUNTER_WIDTH(SAT_W)) dut_sat (
        .auroraUserClk                (clk),
        .auroraReset                  (rst),
        .faStrobe                     (strobe),
        .fofbIndex                    (idx),
        .faX                          (fx),
        .faY                          (fy),
        .faS                          (fs),
        .cwInhibit                    (cw_inh),
        .ccwInhibit                   (ccw_inh),
        .BPM_CW_AXI_STREAM_TX_tdata   (s_cw_d),
        .BPM_CW_AXI_STREAM_TX_tvalid  (s_cw_v),
        .BPM_CW_AXI_STREAM_TX_tlast   (s_cw_l),
        .BPM_CW_AXI_STREAM_TX_tready  (cw_rdy),
        .BPM_CCW_AXI_STREAM_TX_tdata  (s_ccw_d),
        .BPM_CCW_AXI_STREAM_TX_tvalid (s_ccw_v),
        .BPM_CCW_AXI_STREAM_TX_tlast  (s_ccw_l),
        .BPM_CCW_AXI_STREAM_TX_tready (ccw_rdy),
        .cwPacketCount                (s_cw_pkt),
        .ccwPacketCount               (s_ccw_pkt),
        .cwOverrunCount               (s_cw_ovr),
        .ccwOverrunCount              (s_ccw_ovr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] sat(input int raw, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (raw > mx) ? 32'(mx) : 32'(raw);
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < 2; c++) begin
                mq[c].delete();
                pkt_raw[c] = 0;
                ovr_raw[c] = 0;
            end
        end else begin
            for (int c = 0; c < 2; c++) begin
                logic rdy, inh, busy;
                logic [31:0] hdr;
                rdy  = (c == 0) ? cw_rdy : ccw_rdy;
                inh  = (c == 0) ? cw_inh : ccw_inh;
                busy = (mq[c].size() != 0);
                if (busy && rdy) begin
                    void'(mq[c].pop_front());
                    if (mq[c].size() == 0) pkt_raw[c]++;
                end
                if (strobe) begin
                    if (busy) begin
                        ovr_raw[c]++;
                    end else if (!inh) begin
                        hdr = (32'hA5BC << 16) | 32'(idx);
                        mq[c].push_back({1'b0, hdr});
                        mq[c].push_back({1'b0, fx});
                        mq[c].push_back({1'b0, fy});
                        mq[c].push_back({1'b1, fs});
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int c = 0; c < 2; c++) begin
            string pfx;
            logic        av, al;
            logic [31:0] ad, apk, aov, spk, sov;
            pfx = (c == 0) ? "cw" : "ccw";
            av  = (c == 0) ? cw_v : ccw_v;
            al  = (c == 0) ? cw_l : ccw_l;
            ad  = (c == 0) ? cw_d : ccw_d;
            apk = (c == 0) ? 32'(cw_pkt) : 32'(ccw_pkt);
            aov = (c == 0) ? 32'(cw_ovr) : 32'(ccw_ovr);
            spk = (c == 0) ? 32'(s_cw_pkt) : 32'(s_ccw_pkt);
            sov = (c == 0) ? 32'(s_cw_ovr) : 32'(s_ccw_ovr);
            chk({pfx, "_tvalid"}, 32'(av), 32'(mq[c].size() != 0));
            if (mq[c].size() != 0) begin
                chk({pfx, "_tdata"}, ad, mq[c][0][31:0]);
                chk({pfx, "_tlast"}, 32'(al), 32'(mq[c][0][32]));
            end else begin
                chk({pfx, "_tlast_idle"}, 32'(al), 32'd0);
            end
            chk({pfx, "_pkt_count"}, apk, sat(pkt_raw[c], 16));
            chk({pfx, "_ovr_count"}, aov, sat(ovr_raw[c], 16));
            chk({pfx, "_pkt_count_narrow"}, spk, sat(pkt_raw[c], SAT_W));
            chk({pfx, "_ovr_count_narrow"}, sov, sat(ovr_raw[c], SAT_W));
        end
    end

    initial begin
        logic [31:0] w [4];

        rst = 1'b1; strobe = 1'b0; idx = '0; fx = '0; fy = '0; fs = '0;
        cw_inh = 1'b0; ccw_inh = 1'b0; cw_rdy = 1'b1; ccw_rdy = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_cw_tvalid", 32'(cw_v), 32'd0);
        chk("reset_cw_tdata", cw_d, 32'd0);
        chk("reset_ccw_tlast", 32'(ccw_l), 32'd0);
        chk("reset_cw_pkt", 32'(cw_pkt), 32'd0);
        chk("reset_ccw_ovr", 32'(ccw_ovr), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Basic packet on both links.
        w[0] = 32'hA5BC0123; w[1] = 32'h11111111; w[2] = 32'h22222222; w[3] = 32'h33333333;
        idx = 9'h123; fx = w[1]; fy = w[2]; fs = w[3]; strobe = 1'b1;
        tick();
        strobe = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("basic_cw_tvalid", 32'(cw_v), 32'd1);
            chk("basic_cw_word", cw_d, w[i]);
            chk("basic_cw_tlast", 32'(cw_l), (i == 3) ? 32'd1 : 32'd0);
            chk("basic_ccw_word", ccw_d, w[i]);
            chk("basic_ccw_tlast", 32'(ccw_l), (i == 3) ? 32'd1 : 32'd0);
            tick();
        end
        @(negedge clk);
        chk("basic_cw_pkt", 32'(cw_pkt), 32'd1);
        chk("basic_ccw_pkt", 32'(ccw_pkt), 32'd1);
        chk("basic_cw_idle", 32'(cw_v), 32'd0);
        tick();

        // CW backpressure; CCW runs unaffected.
        w[0] = 32'hA5BC00A5; w[1] = 32'h0BADF00D; w[2] = 32'h12345678; w[3] = 32'h87654321;
        cw_rdy = 1'b0; idx = 9'h0A5; fx = w[1]; fy = w[2]; fs = w[3]; strobe = 1'b1;
        tick();
        strobe = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("bp_cw_hold_tdata", cw_d, w[0]);
            chk("bp_cw_hold_tvalid", 32'(cw_v), 32'd1);
            if (k < 4) chk("bp_ccw_word", ccw_d, w[k]);
            if (k == 4) chk("bp_ccw_done", 32'(ccw_v), 32'd0);
            tick();
        end
        cw_rdy = 1'b1;
        repeat (6) tick();
        @(negedge clk);
        chk("bp_cw_pkt", 32'(cw_pkt), 32'd2);
        tick();

        // Overrun: second strobe at N+3 while both links are busy.
        cw_rdy = 1'b0; idx = 9'h055; fx = 32'hCAFE0001; fy = 32'hCAFE0002; fs = 32'hCAFE0003;
        strobe = 1'b1;
        tick();
        strobe = 1'b0;
        tick();
        tick();
        strobe = 1'b1; fx = 32'hDEADBEEF;
        tick();
        strobe = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        chk("ovr_cw_count", 32'(cw_ovr), 32'd1);
        chk("ovr_ccw_count", 32'(ccw_ovr), 32'd1);
        chk("ovr_cw_hdr_held", cw_d, 32'hA5BC0055);
        chk("ovr_ccw_pkt", 32'(ccw_pkt), 32'd3);
        cw_rdy = 1'b1;
        tick();
        @(negedge clk);
        chk("ovr_cw_orig_x", cw_d, 32'hCAFE0001);
        repeat (5) tick();
        @(negedge clk);
        chk("ovr_cw_pkt", 32'(cw_pkt), 32'd3);
        tick();

        // CCW inhibited for the session, released mid-packet.
        ccw_inh = 1'b1; idx = 9'h0F0; fx = 32'h1; fy = 32'h2; fs = 32'h3; strobe = 1'b1;
        tick();
        strobe = 1'b0;
        @(negedge clk);
        chk("inh_ccw_tvalid", 32'(ccw_v), 32'd0);
        tick();
        ccw_inh = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("inh_ccw_tvalid", 32'(ccw_v), 32'd0);
            tick();
        end
        @(negedge clk);
        chk("inh_ccw_pkt", 32'(ccw_pkt), 32'd3);
        chk("inh_ccw_ovr", 32'(ccw_ovr), 32'd1);
        chk("inh_cw_pkt", 32'(cw_pkt), 32'd4);
        tick();

        // Asynchronous reset mid-packet.
        idx = 9'h077; strobe = 1'b1;
        tick();
        strobe = 1'b0;
        tick();
        #1 rst = 1'b1;
        #1;
        chk("arst_cw_tvalid", 32'(cw_v), 32'd0);
        chk("arst_ccw_tvalid", 32'(ccw_v), 32'd0);
        chk("arst_cw_tlast", 32'(cw_l), 32'd0);
        chk("arst_cw_pkt", 32'(cw_pkt), 32'd0);
        chk("arst_ccw_ovr", 32'(ccw_ovr), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        idx = 9'h1C3; fx = 32'hA; fy = 32'hB; fs = 32'hC; strobe = 1'b1;
        tick();
        strobe = 1'b0;
        @(negedge clk);
        chk("post_rst_cw_hdr", cw_d, 32'hA5BC01C3);
        chk("post_rst_ccw_hdr", ccw_d, 32'hA5BC01C3);
        repeat (5) tick();
        @(negedge clk);
        chk("post_rst_cw_pkt", 32'(cw_pkt), 32'd1);
        tick();

        // Maximum-rate run: 70 packets, one every 5 cycles.
        for (int p = 0; p < 70; p++) begin
            idx = 9'($urandom); fx = $urandom; fy = $urandom; fs = $urandom;
            strobe = 1'b1;
            tick();
            strobe = 1'b0;
            repeat (4) tick();
        end
        tick();
        @(negedge clk);
        chk("rate_cw_pkt", 32'(cw_pkt), 32'd71);
        chk("rate_cw_ovr", 32'(cw_ovr), 32'd0);
        chk("sat_cw_pkt_narrow", 32'(s_cw_pkt), 32'h3F);
        chk("sat_ccw_pkt_narrow", 32'(s_ccw_pkt), 32'h3F);
        tick();

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            strobe  = ($urandom_range(0, 3) == 0);
            cw_rdy  = ($urandom_range(0, 3) != 0);
            ccw_rdy = ($urandom_range(0, 3) != 0);
            cw_inh  = ($urandom_range(0, 7) == 0);
            ccw_inh = ($urandom_range(0, 7) == 0);
            idx = 9'($urandom); fx = $urandom; fy = $urandom; fs = $urandom;
            tick();
        end
        strobe = 1'b0; cw_rdy = 1'b1; ccw_rdy = 1'b1;
        repeat (8) tick();
        @(negedge clk);
        chk("end_cw_idle", 32'(cw_v), 32'd0);
        chk("sat_cw_ovr_narrow", 32'(s_cw_ovr), 32'h3F);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
